// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_pkg
// Description : Shared CPU constants, FSM encoding and address checks for DM.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

    localparam int c_DATA_SIZE  = 32;
    localparam int c_ADDR_WIDTH = 12;
    localparam int c_TAG_WIDTH  = 5;

    localparam int c_STATE_W = 3;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_READ    = 3'd1;
    localparam logic [2:0] c_ST_CAPTURE = 3'd2;
    localparam logic [2:0] c_ST_WRITE   = 3'd3;
    localparam logic [2:0] c_ST_RESP    = 3'd4;

    // Rejects a byte address that is not word aligned or lies above the DM.
    function automatic logic addr_rejected(input logic [31:0] addr,
                                           input int unsigned addr_width);
        logic [31:0] w_high;
        w_high = addr >> (addr_width + 2);
        return (addr[1:0] != 2'b00) || (w_high != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Single-request load/store sequencer sitting directly in front
//               of the data memory, with error screening and a response port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DataSize  = c_DATA_SIZE,
    parameter int AddrWidth = c_ADDR_WIDTH,
    parameter int TagWidth  = c_TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [DataSize-1:0]  req_wdata,
    input  logic [TagWidth-1:0]  req_rd,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataSize-1:0]  rsp_rdata,
    output logic [TagWidth-1:0]  rsp_rd,
    output logic                 rsp_write,
    output logic                 rsp_err,

    output logic                 enable_mem,
    output logic                 enable_fetch,
    output logic                 enable_writeback,
    output logic [AddrWidth-1:0] DM_address,
    output logic [DataSize-1:0]  DMin,
    input  logic [DataSize-1:0]  DMout,

    output logic [7:0]           err_count
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;

    logic                 w_accept;
    logic                 w_bad;

    logic [DataSize-1:0]  r_rsp_rdata;
    logic [TagWidth-1:0]  r_rsp_rd;
    logic                 r_rsp_write;
    logic                 r_rsp_err;
    logic [AddrWidth-1:0] r_dm_address;
    logic [DataSize-1:0]  r_dm_in;
    logic [7:0]           r_err_count;

    // Gating with rst keeps req_ready low throughout reset, yet high as soon as it lifts.
    assign req_ready = rst & (r_state == c_ST_IDLE);
    assign w_accept  = req_valid & req_ready;
    assign w_bad     = addr_rejected(req_addr, AddrWidth);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_state_nxt = c_ST_RESP;
                    end else if (req_write) begin
                        w_state_nxt = c_ST_WRITE;
                    end else begin
                        w_state_nxt = c_ST_READ;
                    end
                end
            end
            c_ST_READ:    w_state_nxt = c_ST_CAPTURE;
            c_ST_CAPTURE: w_state_nxt = c_ST_RESP;
            c_ST_WRITE:   w_state_nxt = c_ST_RESP;
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_rdata  <= '0;
            r_rsp_rd     <= '0;
            r_rsp_write  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_dm_address <= '0;
            r_dm_in      <= '0;
            r_err_count  <= 8'd0;
        end else if (w_accept) begin
            r_rsp_rdata <= '0;
            r_rsp_rd    <= req_rd;
            r_rsp_write <= req_write;
            r_rsp_err   <= w_bad;
            if (!w_bad) begin
                r_dm_address <= req_addr[AddrWidth+1:2];
                if (req_write) begin
                    r_dm_in <= req_wdata;
                end
            end
            if (w_bad && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end else if (r_state == c_ST_CAPTURE) begin
            // DM read data is valid throughout the cycle following the READ strobe.
            r_rsp_rdata <= DMout;
        end
    end

    assign rsp_valid        = (r_state == c_ST_RESP);
    assign rsp_rdata        = r_rsp_rdata;
    assign rsp_rd           = r_rsp_rd;
    assign rsp_write        = r_rsp_write;
    assign rsp_err          = r_rsp_err;

    assign enable_mem       = (r_state == c_ST_READ) | (r_state == c_ST_WRITE);
    assign enable_fetch     = (r_state == c_ST_READ);
    assign enable_writeback = (r_state == c_ST_WRITE);
    assign DM_address       = r_dm_address;
    assign DMin             = r_dm_in;

    assign err_count        = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a DM model and a
//               transaction-level reference of memory contents and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int TW = 5;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [31:0]   req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [TW-1:0] req_rd    = '0;
    logic          rsp_ready = 1'b0;

    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [TW-1:0] rsp_rd;
    logic          rsp_write;
    logic          rsp_err;
    logic          enable_mem;
    logic          enable_fetch;
    logic          enable_writeback;
    logic [AW-1:0] DM_address;
    logic [DW-1:0] DMin;
    logic [DW-1:0] DMout = '0;
    logic [7:0]    err_count;

    logic [DW-1:0] dm [4096] = '{default: '0};
    logic [DW-1:0] ref_mem [int];
    int            ref_err_count = 0;
    int            overlap       = 0;
    int            vectors       = 0;
    int            miscompares   = 0;

    mem_access_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rd           (req_rd),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_rd           (rsp_rd),
        .rsp_write        (rsp_write),
        .rsp_err          (rsp_err),
        .enable_mem       (enable_mem),
        .enable_fetch     (enable_fetch),
        .enable_writeback (enable_writeback),
        .DM_address       (DM_address),
        .DMin             (DMin),
        .DMout            (DMout),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory: data appears on DMout after the read edge.
    always @(posedge clk) begin
        if (enable_mem && enable_fetch) DMout <= dm[DM_address];
        if (enable_mem && enable_writeback) dm[DM_address] <= DMin;
    end

    always @(negedge clk) begin
        if (enable_fetch && enable_writeback) overlap <= overlap + 1;
    end

    function automatic bit model_error(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= (32'd1 << AW));
    endfunction

    function automatic int model_latency(input bit wr, input bit err);
        if (err) return 1;
        return wr ? 2 : 3;
    endfunction

    function automatic logic [DW-1:0] model_load(input logic [31:0] a);
        int idx;
        idx = int'(a / 4);
        return ref_mem.exists(idx) ? ref_mem[idx] : '0;
    endfunction

    // Drives one request, follows it to the response handshake and reports what it saw.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [DW-1:0] wdata,
                           input logic [TW-1:0] rd, input int hold,
                           output int lat, output logic [DW-1:0] rdata, output logic [TW-1:0] rd_o,
                           output logic wr_o, output logic err_o, output int n_mem,
                           output int n_fetch, output int n_wb, output logic stable,
                           output logic ready_after);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = TW'($urandom);
        lat = 1; n_mem = 0; n_fetch = 0; n_wb = 0;
        while (1) begin
            if (enable_mem) n_mem++;
            if (enable_fetch) n_fetch++;
            if (enable_writeback) n_wb++;
            if (rsp_valid || lat >= 20) break;
            @(posedge clk);
            #1;
            lat++;
        end
        rdata  = rsp_rdata;
        rd_o   = rsp_rd;
        wr_o   = rsp_write;
        err_o  = rsp_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || req_ready || rsp_rdata !== rdata || rsp_rd !== rd_o ||
                rsp_write !== wr_o || rsp_err !== err_o) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready   = 1'b0;
        ready_after = req_ready;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if ({enable_mem, enable_fetch, enable_writeback} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes: got %b want 000", {enable_mem, enable_fetch, enable_writeback}); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        vectors++; if (DM_address !== '0 || DMin !== '0 || rsp_rdata !== '0) begin miscompares++; $display("FAIL reset_datapath: got addr=%0d din=%h rdata=%h want zeros", DM_address, DMin, rsp_rdata); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_directed_store;
        int lat, nm, nf, nw; logic [DW-1:0] rdata; logic [TW-1:0] rdo; logic wro, erro, st, ra;
        run_txn(1'b1, 32'h70, 32'hDEADBEEF, 5'd2, 0, lat, rdata, rdo, wro, erro, nm, nf, nw, st, ra);
        ref_mem[32'h70 / 4] = 32'hDEADBEEF;
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL store_latency: got %0d want 2", lat); end
        vectors++; if (DM_address !== 12'd28) begin miscompares++; $display("FAIL store_dm_address: got %0d want 28", DM_address); end
        vectors++; if (nm !== 1 || nw !== 1 || nf !== 0) begin miscompares++; $display("FAIL store_strobes: got mem=%0d wb=%0d fetch=%0d want 1 1 0", nm, nw, nf); end
        vectors++; if (erro !== 1'b0 || rdata !== '0 || wro !== 1'b1 || rdo !== 5'd2) begin miscompares++; $display("FAIL store_rsp: got err=%b rdata=%h wr=%b rd=%0d want 0 0 1 2", erro, rdata, wro, rdo); end
        vectors++; if (dm[28] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL store_dm_word: got %h want deadbeef", dm[28]); end
    endtask

    task automatic test_directed_load;
        int lat, nm, nf, nw; logic [DW-1:0] rdata; logic [TW-1:0] rdo; logic wro, erro, st, ra;
        run_txn(1'b0, 32'h70, 32'h0, 5'd7, 0, lat, rdata, rdo, wro, erro, nm, nf, nw, st, ra);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL load_latency: got %0d want 3", lat); end
        vectors++; if (rdata !== model_load(32'h70)) begin miscompares++; $display("FAIL load_rdata: got %h want %h", rdata, model_load(32'h70)); end
        vectors++; if (rdo !== 5'd7 || wro !== 1'b0 || erro !== 1'b0) begin miscompares++; $display("FAIL load_rsp: got rd=%0d wr=%b err=%b want 7 0 0", rdo, wro, erro); end
        vectors++; if (nm !== 1 || nf !== 1 || nw !== 0) begin miscompares++; $display("FAIL load_strobes: got mem=%0d fetch=%0d wb=%0d want 1 1 0", nm, nf, nw); end
    endtask

    task automatic test_errors;
        int lat, nm, nf, nw; logic [DW-1:0] rdata; logic [TW-1:0] rdo; logic wro, erro, st, ra;
        logic [31:0] addrs [2];
        logic        wrs [2];
        addrs[0] = 32'h72;   wrs[0] = 1'b0;
        addrs[1] = 32'h4000; wrs[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            run_txn(wrs[i], addrs[i], 32'hCAFEF00D, TW'(i + 3), 0, lat, rdata, rdo, wro, erro, nm, nf, nw, st, ra);
            if (model_error(addrs[i]) && ref_err_count < 255) ref_err_count++;
            vectors++; if (erro !== 1'b1 || rdata !== '0) begin miscompares++; $display("FAIL err_rsp[%0d]: got err=%b rdata=%h want 1 0", i, erro, rdata); end
            vectors++; if (nm !== 0 || nf !== 0 || nw !== 0) begin miscompares++; $display("FAIL err_strobes[%0d]: got mem=%0d fetch=%0d wb=%0d want 0 0 0", i, nm, nf, nw); end
            vectors++; if (lat !== 1) begin miscompares++; $display("FAIL err_latency[%0d]: got %0d want 1", i, lat); end
            vectors++; if (rdo !== TW'(i + 3) || wro !== wrs[i]) begin miscompares++; $display("FAIL err_echo[%0d]: got rd=%0d wr=%b want %0d %b", i, rdo, wro, i + 3, wrs[i]); end
        end
        vectors++; if (err_count !== 8'(ref_err_count)) begin miscompares++; $display("FAIL err_count: got %0d want %0d", err_count, ref_err_count); end
    endtask

    task automatic test_backpressure;
        int lat, nm, nf, nw; logic [DW-1:0] rdata; logic [TW-1:0] rdo; logic wro, erro, st, ra;
        run_txn(1'b0, 32'h70, 32'h0, 5'd21, 5, lat, rdata, rdo, wro, erro, nm, nf, nw, st, ra);
        vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL bp_stable: got %b want 1", st); end
        vectors++; if (ra !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after: got %b want 1", ra); end
        vectors++; if (rdata !== model_load(32'h70) || rdo !== 5'd21) begin miscompares++; $display("FAIL bp_rsp: got rdata=%h rd=%0d want %h 21", rdata, rdo, model_load(32'h70)); end
    endtask

    task automatic test_random;
        int lat, nm, nf, nw, hold; logic [DW-1:0] rdata, wdata, exp_rdata; logic [TW-1:0] rd, rdo;
        logic wro, erro, st, ra, wr; logic [31:0] addr; int unsigned sel; bit bad;
        for (int n = 0; n < 60; n++) begin
            sel   = $urandom_range(0, 9);
            wr    = 1'($urandom);
            wdata = $urandom;
            rd    = TW'($urandom);
            hold  = $urandom_range(0, 3);
            if (sel < 6)       addr = 32'($urandom_range(0, 15)) * 4;
            else if (sel == 6) addr = 32'h3FFC;
            else if (sel < 9)  addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else               addr = $urandom | 32'h0000_4000;
            bad       = model_error(addr);
            exp_rdata = (bad || wr) ? '0 : model_load(addr);
            run_txn(wr, addr, wdata, rd, hold, lat, rdata, rdo, wro, erro, nm, nf, nw, st, ra);
            if (bad && ref_err_count < 255) ref_err_count++;
            if (!bad && wr) ref_mem[int'(addr / 4)] = wdata;
            vectors++; if (lat !== model_latency(wr, bad)) begin miscompares++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, lat, model_latency(wr, bad)); end
            vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rdata, exp_rdata); end
            vectors++; if (rdo !== rd || wro !== wr || erro !== bad) begin miscompares++; $display("FAIL rnd_echo[%0d]: got rd=%0d wr=%b err=%b want %0d %b %b", n, rdo, wro, erro, rd, wr, bad); end
            vectors++; if (nm !== (bad ? 0 : 1) || nf !== ((!bad && !wr) ? 1 : 0) || nw !== ((!bad && wr) ? 1 : 0)) begin miscompares++; $display("FAIL rnd_strobes[%0d]: got mem=%0d fetch=%0d wb=%0d", n, nm, nf, nw); end
            vectors++; if (st !== 1'b1 || ra !== 1'b1) begin miscompares++; $display("FAIL rnd_handshake[%0d]: got stable=%b ready=%b want 1 1", n, st, ra); end
            vectors++; if (err_count !== 8'(ref_err_count)) begin miscompares++; $display("FAIL rnd_err_count[%0d]: got %0d want %0d", n, err_count, ref_err_count); end
        end
    endtask

    task automatic test_reset_mid_read;
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h70; req_rd = 5'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vectors++; if (enable_mem !== 1'b1 || enable_fetch !== 1'b1) begin miscompares++; $display("FAIL mid_read_strobes: got mem=%b fetch=%b want 1 1", enable_mem, enable_fetch); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if ({enable_mem, enable_fetch, enable_writeback} !== 3'b000) begin miscompares++; $display("FAIL mid_reset_strobes: got %b want 000", {enable_mem, enable_fetch, enable_writeback}); end
        vectors++; if (req_ready !== 1'b0 || err_count !== 8'd0) begin miscompares++; $display("FAIL mid_reset_outputs: got ready=%b errs=%0d want 0 0", req_ready, err_count); end
        ref_err_count = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ready: got %b want 1", req_ready); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL mid_reset_no_rsp: got rsp_valid seen=%b want 0", seen); end
    endtask

    task automatic test_saturation;
        int lat, nm, nf, nw; logic [DW-1:0] rdata; logic [TW-1:0] rdo; logic wro, erro, st, ra;
        logic [31:0] addr;
        for (int n = 0; n < 256; n++) begin
            addr = 32'($urandom_range(0, 4095)) * 4 + 32'($urandom_range(1, 3));
            run_txn(1'($urandom), addr, $urandom, TW'($urandom), 0, lat, rdata, rdo, wro, erro, nm, nf, nw, st, ra);
            if (ref_err_count < 255) ref_err_count++;
            if (n == 254) begin
                vectors++; if (err_count !== 8'(ref_err_count)) begin miscompares++; $display("FAIL sat_reach: got %0d want %0d", err_count, ref_err_count); end
            end
        end
        vectors++; if (err_count !== 8'(ref_err_count)) begin miscompares++; $display("FAIL sat_hold: got %0d want %0d", err_count, ref_err_count); end
    endtask

    task automatic test_strobe_exclusive;
        vectors++; if (overlap !== 0) begin miscompares++; $display("FAIL fetch_wb_overlap: got %0d cycles want 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_directed_store();
        test_directed_load();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_mid_read();
        test_saturation();
        test_strobe_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DataSize, default 32: data word width.
REQ-002 SHALL have parameter AddrWidth, default 12: DM word-address width, giving 4096 words.
REQ-003 SHALL have parameter TagWidth, default 5: destination-register tag width.
REQ-004 SHALL have port clk  in  1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid in 1 and req_ready out 1: upstream request handshake.
REQ-007 SHALL have port req_write  in  1: 1 = store, 0 = load.
REQ-008 SHALL have ports req_addr in 32 (byte address) and req_wdata in DataSize (store data).
REQ-009 SHALL have port req_rd  in  TagWidth: load destination tag.
REQ-010 SHALL have ports rsp_valid out 1 and rsp_ready in 1: downstream response handshake.
REQ-011 SHALL have ports rsp_rdata out DataSize, rsp_rd out TagWidth, rsp_write out 1, rsp_err out 1.
REQ-012 SHALL have ports enable_mem, enable_fetch, enable_writeback  out  1 each: DM strobes.
REQ-013 SHALL have ports DM_address out AddrWidth, DMin out DataSize, DMout in DataSize: DM data path.
REQ-014 SHALL have port err_count  out  8: saturating count of rejected requests.

Function
REQ-015 SHALL implement FSM states IDLE, READ, CAPTURE, WRITE, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
REQ-017 SHALL flag an error on acceptance when req_addr[1:0]!=0 (misaligned) or req_addr[31:AddrWidth+2]!=0 (out of range).
REQ-018 SHALL, for an error request, go IDLE->RESP with rsp_err=1 and rsp_rdata=0, and SHALL assert no DM strobe.
REQ-019 SHALL, for a valid load, go IDLE->READ; DM_address is registered from req_addr[AddrWidth+1:2]; enable_mem=enable_fetch=1 for exactly the READ cycle.
REQ-020 SHALL go READ->CAPTURE, then CAPTURE->RESP; DMout is latched into rsp_rdata on the CAPTURE->RESP edge.
REQ-021 SHALL, for a valid store, go IDLE->WRITE; DM_address and DMin are registered; enable_mem=enable_writeback=1 for exactly the WRITE cycle; then WRITE->RESP with rsp_rdata=0.
REQ-022 SHALL never assert enable_fetch and enable_writeback in the same cycle.
REQ-023 SHALL drive rsp_valid=1 only in RESP and hold rsp_* stable until rsp_valid && rsp_ready, then go RESP->IDLE.
REQ-024 SHALL echo req_rd into rsp_rd and req_write into rsp_write for every response, including error responses.
REQ-025 SHALL meet these latencies from the accept edge to rsp_valid high: load 3 cycles, store 2 cycles, error 1 cycle.
REQ-026 SHALL increment err_count by 1 per error acceptance and saturate at 255.
REQ-027 SHALL hold DM strobes at 0 in IDLE, CAPTURE and RESP.

Reset
REQ-028 SHALL, while rst=0, force state=IDLE and all outputs to 0, including req_ready=0, err_count=0 and every strobe, without waiting for a clock edge.
REQ-029 SHALL drop an in-flight request when reset asserts mid-operation; no response is issued after release.
REQ-030 SHALL present req_ready=1 in the first cycle after rst returns high.

Structure
REQ-031 SHALL take the FSM state encoding and the DataSize, AddrWidth and TagWidth defaults from the shared CPU package.
REQ-032 SHALL be a single module with no sub-modules; it sits directly upstream of DM and drives all DM ports.

Verification
REQ-033 SHALL cover: store 0xDEADBEEF to 0x70 -> DM_address=28; enable_mem and enable_writeback high for 1 cycle; rsp_valid 2 cycles after accept; rsp_err=0.
REQ-034 SHALL cover: load from 0x70 with req_rd=7, after the REQ-033 store -> rsp_rdata=0xDEADBEEF, rsp_rd=7, rsp_valid 3 cycles after accept.
REQ-035 SHALL cover: load from 0x72, then store to 0x4000 -> both get rsp_err=1 and rsp_rdata=0; no enable_mem; err_count=2.
REQ-036 SHALL cover: rsp_ready held low 5 cycles during RESP -> rsp_* stable, req_ready=0; accept resumes the cycle after the handshake.
REQ-037 SHALL cover: rst=0 asserted during READ -> strobes fall immediately; no rsp_valid after release; req_ready=1 on the first cycle after release.
REQ-038 SHALL cover: 256 misaligned requests -> err_count stays 255.
